// File: rtl/bp_pkg.sv
// Shared constants, state type and counter helper for the branch predictor.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } bp_state_e;

    // Two-bit saturating counter step towards the observed outcome.
    function automatic logic [1:0] sat2_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_bht.sv
// Branch history table: 2^IDX_W two-bit counters, two async read ports
// (fetch lookup, resolve lookup) and one synchronous write port.
module bp_bht
    import bp_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic [IDX_W-1:0] upd_idx,
    output logic [1:0]       upd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_ctr
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] bht_q [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [1:0] ent_d;

            always_comb begin
                ent_d = bht_q[gi];
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    ent_d = wr_ctr;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bht_q[gi] <= WNT;
                end else begin
                    bht_q[gi] <= ent_d;
                end
            end
        end
    endgenerate

    // No write-to-read bypass: same-cycle reads see the old counter.
    assign rd_ctr  = bht_q[rd_idx];
    assign upd_ctr = bht_q[upd_idx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic 2-bit branch predictor with mispredict flush/redirect,
// table-clear sweep and branch statistics.
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_en,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             mem_valid,
    input  logic             mem_is_branch,
    input  logic [PC_W-1:0]  mem_pc,
    input  logic [PC_W-1:0]  mem_target,
    input  logic             mem_taken,
    input  logic             mem_pred,
    input  logic             bht_clr,
    output logic             bht_busy,
    output logic             ifidflush,
    output logic             idexflush,
    output logic             exmemflush,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0] rd_idx, mem_idx, wr_idx;
    logic [1:0]       rd_ctr, upd_ctr, wr_ctr;
    logic             wr_en;
    logic             res, mis;
    logic             unused_pc_bits;

    assign rd_idx  = if_pc[IDX_W+1:2];
    assign mem_idx = mem_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

    assign res = mem_valid & mem_is_branch;
    assign mis = res & (mem_taken != mem_pred);

    bp_bht #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (rd_idx),
        .rd_ctr  (rd_ctr),
        .upd_idx (mem_idx),
        .upd_ctr (upd_ctr),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_ctr  (wr_ctr)
    );

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        wr_en     = 1'b0;
        wr_idx    = mem_idx;
        wr_ctr    = sat2_next(upd_ctr, mem_taken);

        if (bht_clr) begin
            // A clear request always (re)starts the sweep and drops this cycle's event.
            state_d   = CLEAR;
            clr_ptr_d = '0;
            br_cnt_d  = '0;
            mis_cnt_d = '0;
        end else begin
            if (res && (br_cnt_q != '1)) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (mis && (mis_cnt_q != '1)) begin
                mis_cnt_d = mis_cnt_q + CNT_W'(1);
            end

            if (state_q == CLEAR) begin
                wr_en     = 1'b1;
                wr_idx    = clr_ptr_q;
                wr_ctr    = WNT;
                clr_ptr_d = clr_ptr_q + IDX_W'(1);
                if (clr_ptr_q == '1) begin
                    state_d = RUN;
                end
            end else if (res) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            clr_ptr_q <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign bht_busy   = (state_q == CLEAR);
    assign pred_taken = pred_en & ~bht_busy & rd_ctr[1];

    assign ifidflush      = mis;
    assign idexflush      = mis;
    assign exmemflush     = mis;
    assign redirect_valid = mis;
    assign redirect_pc    = mis ? (mem_taken ? mem_target : mem_pc + PC_W'(4)) : '0;

    assign br_cnt  = br_cnt_q;
    assign mis_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Randomized self-checking bench for branch_predict_ctrl against a behavioural model.
module tb_branch_predict_ctrl;

    localparam int IDX_W = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam int NENT  = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pred_en = 1'b0;
    logic [PC_W-1:0]  if_pc = '0;
    logic             pred_taken;
    logic             mem_valid = 1'b0;
    logic             mem_is_branch = 1'b0;
    logic [PC_W-1:0]  mem_pc = '0;
    logic [PC_W-1:0]  mem_target = '0;
    logic             mem_taken = 1'b0;
    logic             mem_pred = 1'b0;
    logic             bht_clr = 1'b0;
    logic             bht_busy;
    logic             ifidflush, idexflush, exmemflush;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] br_cnt, mis_cnt;

    branch_predict_ctrl #(
        .IDX_W (IDX_W),
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_en        (pred_en),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .mem_valid      (mem_valid),
        .mem_is_branch  (mem_is_branch),
        .mem_pc         (mem_pc),
        .mem_target     (mem_target),
        .mem_taken      (mem_taken),
        .mem_pred       (mem_pred),
        .bht_clr        (bht_clr),
        .bht_busy       (bht_busy),
        .ifidflush      (ifidflush),
        .idexflush      (idexflush),
        .exmemflush     (exmemflush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .br_cnt         (br_cnt),
        .mis_cnt        (mis_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: counters as small integers 0..3, sweep as cycles remaining.
    int m_ctr [NENT];
    int m_clr_left;
    int m_br, m_mis;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int max_cnt = (1 << CNT_W) - 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) m_ctr[i] = 1;
        m_clr_left = 0;
        m_br  = 0;
        m_mis = 0;
    endtask

    function automatic int slot(input logic [PC_W-1:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    task automatic run_cycle(input logic clr, input logic en, input logic [PC_W-1:0] ipc,
                             input logic vld, input logic isbr, input logic [PC_W-1:0] mpc,
                             input logic [PC_W-1:0] tgt, input logic tkn, input logic prd);
        logic res, mis, e_pred;
        logic [PC_W-1:0] e_rpc;
        @(negedge clk);
        bht_clr = clr; pred_en = en; if_pc = ipc;
        mem_valid = vld; mem_is_branch = isbr; mem_pc = mpc;
        mem_target = tgt; mem_taken = tkn; mem_pred = prd;
        #1;
        res    = vld & isbr;
        mis    = res & (tkn != prd);
        e_pred = en && (m_clr_left == 0) && (m_ctr[slot(ipc)] >= 2);
        e_rpc  = mis ? (tkn ? tgt : mpc + 32'd4) : 32'd0;
        check("pred_taken", 32'(pred_taken), 32'(e_pred));
        check("bht_busy", 32'(bht_busy), 32'(m_clr_left != 0));
        check("flushes", {29'd0, ifidflush, idexflush, exmemflush}, {29'd0, mis, mis, mis});
        check("redirect_valid", 32'(redirect_valid), 32'(mis));
        check("redirect_pc", redirect_pc, e_rpc);
        check("br_cnt", 32'(br_cnt), 32'(m_br));
        check("mis_cnt", 32'(mis_cnt), 32'(m_mis));
        @(posedge clk);
        cyc++;
        if (clr) begin
            // Table contents are masked until the sweep ends, when all read weakly not-taken.
            for (int i = 0; i < NENT; i++) m_ctr[i] = 1;
            m_clr_left = NENT;
            m_br  = 0;
            m_mis = 0;
        end else begin
            if (res && m_br < max_cnt) m_br++;
            if (mis && m_mis < max_cnt) m_mis++;
            if (m_clr_left > 0) begin
                m_clr_left--;
            end else if (res) begin
                if (tkn) m_ctr[slot(mpc)] = (m_ctr[slot(mpc)] == 3) ? 3 : m_ctr[slot(mpc)] + 1;
                else     m_ctr[slot(mpc)] = (m_ctr[slot(mpc)] == 0) ? 0 : m_ctr[slot(mpc)] - 1;
            end
        end
    endtask

    task automatic rand_cycle(input int clr_pct);
        logic [PC_W-1:0] mpc, ipc;
        mpc = ($urandom & 32'hFFFF_FFC0) | PC_W'($urandom_range(0, 15) << 2) | PC_W'($urandom & 3);
        if ($urandom_range(0, 19) == 0) mpc = 32'hFFFF_FFFC;
        ipc = ($urandom_range(0, 1) == 0) ? mpc : PC_W'($urandom);
        run_cycle($urandom_range(0, 99) < clr_pct, $urandom_range(0, 3) != 0, ipc,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, mpc,
                  $urandom, 1'($urandom), 1'($urandom));
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state: both probes read weakly not-taken counters.
        run_cycle(0, 1, 32'h0, 0, 0, 0, 0, 0, 0);
        run_cycle(0, 1, 32'h3C, 0, 0, 0, 0, 0, 0);

        // Training at 0x40: two taken mispredicts.
        run_cycle(0, 1, 32'h40, 1, 1, 32'h40, 32'h100, 1, 0);
        check("rpc_first", redirect_pc, 32'h100);
        run_cycle(0, 1, 32'h40, 1, 1, 32'h40, 32'h100, 1, 0);
        check("pred_trained", 32'(pred_taken), 32'd1);
        run_cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
        check("br_after_train", 32'(br_cnt), 32'd2);

        // Saturate, then fall through once.
        repeat (5) run_cycle(0, 1, 32'h40, 1, 1, 32'h40, 32'h100, 1, 1);
        run_cycle(0, 1, 32'h40, 1, 1, 32'h40, 32'h100, 0, 1);
        check("rpc_fallthru", redirect_pc, 32'h44);
        run_cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
        check("pred_after_fall", 32'(pred_taken), 32'd1);

        // Clear sweep with a mispredict in the middle.
        run_cycle(1, 1, 32'h40, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NENT; i++) begin
            run_cycle(0, 1, 32'h40, i == 5, 1, 32'h40, 32'h200, 1, 0);
        end
        run_cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
        check("busy_after_sweep", 32'(bht_busy), 32'd0);

        // Clear colliding with a resolve, and a restart mid-sweep.
        run_cycle(1, 1, 32'h80, 1, 1, 32'h80, 32'h0, 1, 0);
        repeat (3) run_cycle(0, 1, 32'h80, 0, 0, 0, 0, 0, 0);
        run_cycle(1, 1, 32'h80, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset at sweep cycle 7.
        repeat (7) run_cycle(0, 1, 32'h0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        bht_clr = 0; mem_valid = 0; mem_is_branch = 0; pred_en = 1;
        rst_n = 1'b0;
        #1;
        check("busy_async_rst", 32'(bht_busy), 32'd0);
        check("br_async_rst", 32'(br_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Prediction disabled while training continues.
        repeat (4) run_cycle(0, 0, 32'h10, 1, 1, 32'h10, 32'h300, 1, 0);
        run_cycle(0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
        check("pred_en_trained", 32'(pred_taken), 32'd1);

        // Random traffic: long stretches without clears to reach counter saturation.
        repeat (300) rand_cycle(0);
        repeat (1500) rand_cycle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
